// File: rtl/exe_stage_memreq_pkg.sv
// exe_stage_memreq_pkg
// Shared constants for the EXE stage: exception bit position, mem_all field
// indices, one-hot FSM encodings for the data request tracker, SRAM size
// codes, one-hot ALU op indices, and a store-data lane replication helper.
package exe_stage_memreq_pkg;

  localparam int EXC_W       = 15;
  localparam int EXC_ALE_IDX = 9;

  // mem_all = {mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w}
  localparam int MEM_WE = 7;
  localparam int LD_B   = 6;
  localparam int LD_H   = 5;
  localparam int LD_W   = 4;
  localparam int LD_SE  = 3;
  localparam int ST_B   = 2;
  localparam int ST_H   = 1;
  localparam int ST_W   = 0;

  // Data request tracker, one-hot
  localparam logic [3:0] S_IDLE   = 4'b0001;
  localparam logic [3:0] S_REQ    = 4'b0010;
  localparam logic [3:0] S_ZOMBIE = 4'b0100;
  localparam logic [3:0] S_DONE   = 4'b1000;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // One-hot ALU op bit positions
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Replicate store data across byte lanes so the strobes pick the right copy
  function automatic logic [31:0] st_wdata(input logic is_b, input logic is_h,
                                           input logic [31:0] rkd);
    if (is_b)      st_wdata = {4{rkd[7:0]}};
    else if (is_h) st_wdata = {2{rkd[15:0]}};
    else           st_wdata = rkd;
  endfunction

endpackage

// File: rtl/exe_stage_memreq_alu.sv
// exe_stage_memreq_alu
// Purely combinational ALU with a one-hot 12-bit op select.
// Ports: i_alu_op (one-hot op), i_src1/i_src2 (operands), o_result.
module exe_stage_memreq_alu
  import exe_stage_memreq_pkg::*;
(
  input  logic [11:0] i_alu_op,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  output logic [31:0] o_result
);

  logic        w_sub_en;
  logic [31:0] w_b;
  logic [32:0] w_sum;
  logic        w_slt, w_sltu;
  logic [31:0] w_sll, w_srl, w_sra;

  // One shared adder serves add, sub and both compares
  assign w_sub_en = i_alu_op[ALU_SUB] | i_alu_op[ALU_SLT] | i_alu_op[ALU_SLTU];
  assign w_b      = w_sub_en ? ~i_src2 : i_src2;
  assign w_sum    = {1'b0, i_src1} + {1'b0, w_b} + {32'd0, w_sub_en};

  assign w_slt  = (i_src1[31] & ~i_src2[31]) |
                  (~(i_src1[31] ^ i_src2[31]) & w_sum[31]);
  assign w_sltu = ~w_sum[32];

  assign w_sll = i_src1 << i_src2[4:0];
  assign w_srl = i_src1 >> i_src2[4:0];
  assign w_sra = 32'($signed(i_src1) >>> i_src2[4:0]);

  assign o_result = ({32{i_alu_op[ALU_ADD] | i_alu_op[ALU_SUB]}} & w_sum[31:0])
                  | ({32{i_alu_op[ALU_SLT]}}  & {31'd0, w_slt})
                  | ({32{i_alu_op[ALU_SLTU]}} & {31'd0, w_sltu})
                  | ({32{i_alu_op[ALU_AND]}}  & (i_src1 & i_src2))
                  | ({32{i_alu_op[ALU_NOR]}}  & ~(i_src1 | i_src2))
                  | ({32{i_alu_op[ALU_OR]}}   & (i_src1 | i_src2))
                  | ({32{i_alu_op[ALU_XOR]}}  & (i_src1 ^ i_src2))
                  | ({32{i_alu_op[ALU_SLL]}}  & w_sll)
                  | ({32{i_alu_op[ALU_SRL]}}  & w_srl)
                  | ({32{i_alu_op[ALU_SRA]}}  & w_sra)
                  | ({32{i_alu_op[ALU_LUI]}}  & i_src2);

endmodule

// File: rtl/exe_stage_memreq.sv
// exe_stage_memreq
// EXE pipeline stage feeding MEMstate. Latches the ID payload, computes the
// result with the alu, flags misaligned loads/stores (ALE) and drives an
// SRAM-like data request (req/addr_ok). Requests squashed by a flush after
// acceptance are counted so MEMstate can discard their late data_ok.
// Ports:
//   clk, resetn (sync, active-low)
//   id_* / id_to_exe_valid / exe_allowin   : handshake + payload from ID
//   exe_* / exe_to_mem_valid / exe_ready_go: handshake + payload to MEM
//   mem/wb_pipeline_block, cancel_exc_ertn_tlbflush : hazards and flush
//   exe_drop_data_ok : next data_ok belongs to a squashed request
//   data_sram_*      : data-side request channel
module exe_stage_memreq
  import exe_stage_memreq_pkg::*;
#(
  parameter int DROP_CNT_W = 2
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_to_exe_valid,
  output logic        exe_allowin,
  input  logic [31:0] id_pc,
  input  logic [11:0] id_alu_op,
  input  logic [31:0] id_alu_src1,
  input  logic [31:0] id_alu_src2,
  input  logic [31:0] id_rkd_value,
  input  logic        id_res_from_mem,
  input  logic [7:0]  id_mem_all,
  input  logic [5:0]  id_rf_all,
  input  logic [14:0] id_exc_rf,
  input  logic [79:0] id_csr_rf,
  input  logic [2:0]  id_tlb_rf,
  input  logic        mem_allowin,
  input  logic        mem_pipeline_block,
  input  logic        wb_pipeline_block,
  input  logic        cancel_exc_ertn_tlbflush,
  output logic        exe_to_mem_valid,
  output logic        exe_ready_go,
  output logic [31:0] exe_pc,
  output logic [31:0] exe_result,
  output logic [31:0] exe_rkd_value,
  output logic        exe_res_from_mem,
  output logic [7:0]  exe_mem_all,
  output logic [5:0]  exe_rf_all,
  output logic [14:0] exe_exc_rf,
  output logic [79:0] exe_csr_rf,
  output logic [2:0]  exe_tlb_rf,
  output logic        exe_drop_data_ok,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok
);

  logic                  r_exe_valid;
  logic [31:0]           r_pc, r_src1, r_src2, r_rkd;
  logic [11:0]           r_alu_op;
  logic                  r_res_from_mem;
  logic [7:0]            r_mem_all;
  logic [5:0]            r_rf_all;
  logic [14:0]           r_exc_rf;
  logic [79:0]           r_csr_rf;
  logic [2:0]            r_tlb_rf;
  logic [3:0]            r_state;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic [3:0]  w_state_nxt;
  logic [31:0] w_result, w_addr;
  logic [14:0] w_exc;
  logic        w_cancel, w_accept, w_ale, w_is_mem, w_has_exc, w_may_issue, w_hs;
  logic        w_is_b, w_is_h, w_is_w;
  logic        w_st_idle, w_st_req, w_st_zombie, w_st_done;
  logic        w_drop_inc, w_drop_dec;

  exe_stage_memreq_alu u_alu (
    .i_alu_op (r_alu_op),
    .i_src1   (r_src1),
    .i_src2   (r_src2),
    .o_result (w_result)
  );

  assign w_cancel = cancel_exc_ertn_tlbflush;
  assign w_addr   = w_result;

  assign w_is_b = r_mem_all[LD_B] | r_mem_all[ST_B];
  assign w_is_h = r_mem_all[LD_H] | r_mem_all[ST_H];
  assign w_is_w = r_mem_all[LD_W] | r_mem_all[ST_W];

  assign w_ale = r_exe_valid & ((w_is_h & w_addr[0]) | (w_is_w & (|w_addr[1:0])));

  always_comb begin
    w_exc              = r_exc_rf;
    w_exc[EXC_ALE_IDX] = r_exc_rf[EXC_ALE_IDX] | w_ale;
  end

  assign w_is_mem    = r_res_from_mem | r_mem_all[MEM_WE];
  assign w_has_exc   = |w_exc;
  assign w_may_issue = r_exe_valid & w_is_mem & ~w_has_exc & ~mem_pipeline_block
                     & ~wb_pipeline_block & ~w_cancel;

  assign w_st_idle   = (r_state == S_IDLE);
  assign w_st_req    = (r_state == S_REQ);
  assign w_st_zombie = (r_state == S_ZOMBIE);
  assign w_st_done   = (r_state == S_DONE);

  // Once raised, req stays up until addr_ok, even after a flush
  assign data_sram_req = (w_st_idle & w_may_issue) | w_st_req | w_st_zombie;
  assign w_hs          = data_sram_req & data_sram_addr_ok;

  assign exe_ready_go = (~w_is_mem | w_has_exc) ? 1'b1
                      : (w_st_done | (w_st_idle & w_hs));
  // A zombie request still owns the channel; hold ID off until it drains
  assign exe_allowin      = ~w_st_zombie & (~r_exe_valid | (exe_ready_go & mem_allowin));
  assign exe_to_mem_valid = r_exe_valid & exe_ready_go;
  assign w_accept         = exe_allowin & id_to_exe_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (data_sram_req) begin
        // Handshake in the same cycle the next op is latched: that op has
        // not issued yet, so stay in IDLE instead of parking in DONE.
        if (data_sram_addr_ok) w_state_nxt = w_accept ? S_IDLE : S_DONE;
        else                   w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (data_sram_addr_ok) w_state_nxt = w_cancel ? S_IDLE : S_DONE;
        else if (w_cancel)     w_state_nxt = S_ZOMBIE;
      end
      S_ZOMBIE: if (data_sram_addr_ok) w_state_nxt = S_IDLE;
      S_DONE:   if (w_accept | w_cancel) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn || w_cancel) r_exe_valid <= 1'b0;
    else if (exe_allowin)    r_exe_valid <= id_to_exe_valid;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc           <= '0;
      r_alu_op       <= '0;
      r_src1         <= '0;
      r_src2         <= '0;
      r_rkd          <= '0;
      r_res_from_mem <= 1'b0;
      r_mem_all      <= '0;
      r_rf_all       <= '0;
      r_exc_rf       <= '0;
      r_csr_rf       <= '0;
      r_tlb_rf       <= '0;
    end else if (w_accept) begin
      r_pc           <= id_pc;
      r_alu_op       <= id_alu_op;
      r_src1         <= id_alu_src1;
      r_src2         <= id_alu_src2;
      r_rkd          <= id_rkd_value;
      r_res_from_mem <= id_res_from_mem;
      r_mem_all      <= id_mem_all;
      r_rf_all       <= id_rf_all;
      r_exc_rf       <= id_exc_rf;
      r_csr_rf       <= id_csr_rf;
      r_tlb_rf       <= id_tlb_rf;
    end
  end

  // Squashed-request counter: squashed handshakes return data_ok ahead of
  // anything MEMstate issues later, so the oldest data_ok is dropped first.
  assign w_drop_inc = w_hs & ((w_st_req & w_cancel) | w_st_zombie);
  assign w_drop_dec = data_sram_data_ok & (|r_drop_cnt);

  always_ff @(posedge clk) begin
    if (!resetn) r_drop_cnt <= '0;
    else if (w_drop_inc && !w_drop_dec) begin
      if (!(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end else if (!w_drop_inc && w_drop_dec) r_drop_cnt <= r_drop_cnt - DROP_CNT_W'(1);
  end

  a_drop_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(w_drop_inc && !w_drop_dec && (&r_drop_cnt)));

  assign exe_drop_data_ok = |r_drop_cnt;

  assign data_sram_wr    = r_mem_all[MEM_WE];
  assign data_sram_addr  = w_addr;
  assign data_sram_size  = w_is_b ? SIZE_B : (w_is_h ? SIZE_H : SIZE_W);
  assign data_sram_wdata = st_wdata(r_mem_all[ST_B], r_mem_all[ST_H], r_rkd);

  always_comb begin
    data_sram_wstrb = 4'h0;
    if (r_mem_all[MEM_WE]) begin
      if (r_mem_all[ST_B])      data_sram_wstrb = 4'b0001 << w_addr[1:0];
      else if (r_mem_all[ST_H]) data_sram_wstrb = w_addr[1] ? 4'b1100 : 4'b0011;
      else                      data_sram_wstrb = 4'hF;
    end
  end

  assign exe_pc           = r_pc;
  assign exe_result       = w_result;
  assign exe_rkd_value    = r_rkd;
  assign exe_res_from_mem = r_res_from_mem;
  assign exe_mem_all      = r_mem_all;
  assign exe_rf_all       = r_rf_all;
  assign exe_exc_rf       = w_exc;
  assign exe_csr_rf       = r_csr_rf;
  assign exe_tlb_rf       = r_tlb_rf;

endmodule

// File: tb/tb_exe_stage_memreq.sv
// tb_exe_stage_memreq
// Directed stimulus; expected SRAM handshakes and EXE->MEM transfers are
// queued when issued and checked by an independent negedge monitor.
module tb_exe_stage_memreq;
  import exe_stage_memreq_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        id_to_exe_valid, exe_allowin;
  logic [31:0] id_pc, id_alu_src1, id_alu_src2, id_rkd_value;
  logic [11:0] id_alu_op;
  logic        id_res_from_mem;
  logic [7:0]  id_mem_all;
  logic [5:0]  id_rf_all;
  logic [14:0] id_exc_rf;
  logic [79:0] id_csr_rf;
  logic [2:0]  id_tlb_rf;
  logic        mem_allowin, mem_pipeline_block, wb_pipeline_block, cancel;
  logic        exe_to_mem_valid, exe_ready_go;
  logic [31:0] exe_pc, exe_result, exe_rkd_value;
  logic        exe_res_from_mem;
  logic [7:0]  exe_mem_all;
  logic [5:0]  exe_rf_all;
  logic [14:0] exe_exc_rf;
  logic [79:0] exe_csr_rf;
  logic [2:0]  exe_tlb_rf;
  logic        exe_drop_data_ok;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;

  exe_stage_memreq dut (
    .clk(clk), .resetn(resetn),
    .id_to_exe_valid(id_to_exe_valid), .exe_allowin(exe_allowin),
    .id_pc(id_pc), .id_alu_op(id_alu_op), .id_alu_src1(id_alu_src1),
    .id_alu_src2(id_alu_src2), .id_rkd_value(id_rkd_value),
    .id_res_from_mem(id_res_from_mem), .id_mem_all(id_mem_all),
    .id_rf_all(id_rf_all), .id_exc_rf(id_exc_rf), .id_csr_rf(id_csr_rf),
    .id_tlb_rf(id_tlb_rf), .mem_allowin(mem_allowin),
    .mem_pipeline_block(mem_pipeline_block), .wb_pipeline_block(wb_pipeline_block),
    .cancel_exc_ertn_tlbflush(cancel),
    .exe_to_mem_valid(exe_to_mem_valid), .exe_ready_go(exe_ready_go),
    .exe_pc(exe_pc), .exe_result(exe_result), .exe_rkd_value(exe_rkd_value),
    .exe_res_from_mem(exe_res_from_mem), .exe_mem_all(exe_mem_all),
    .exe_rf_all(exe_rf_all), .exe_exc_rf(exe_exc_rf), .exe_csr_rf(exe_csr_rf),
    .exe_tlb_rf(exe_tlb_rf), .exe_drop_data_ok(exe_drop_data_ok),
    .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok)
  );

  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [7:0]  M_LDW = 8'b0001_0000, M_LDH = 8'b0010_0000;
  localparam logic [7:0]  M_STB = 8'b1000_0100, M_STH = 8'b1000_0010, M_STW = 8'b1000_0001;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; logic wr; logic [1:0] size; logic [3:0] wstrb; logic [31:0] wdata; } hs_t;
  typedef struct { logic [31:0] pc; logic [31:0] res; logic ale; logic [5:0] rf; } xf_t;
  hs_t hs_q[$];
  xf_t xf_q[$];
  hs_t eh;
  xf_t ex;

  // Monitor: compares every SRAM handshake and every EXE->MEM transfer
  always @(negedge clk) if (resetn) begin
    if (req && addr_ok) begin
      if (hs_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_hs: got addr %0h, none expected", addr);
      end else begin
        eh = hs_q.pop_front();
        chk("hs_addr", addr, eh.addr);
        chk("hs_wr", wr, eh.wr);
        chk("hs_size", size, eh.size);
        chk("hs_wstrb", wstrb, eh.wstrb);
        if (eh.wr) chk("hs_wdata", wdata, eh.wdata);
      end
    end
    if (exe_to_mem_valid && mem_allowin) begin
      if (xf_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_xfer: got pc %0h, none expected", exe_pc);
      end else begin
        ex = xf_q.pop_front();
        chk("xf_pc", exe_pc, ex.pc);
        chk("xf_result", exe_result, ex.res);
        chk("xf_ale", exe_exc_rf[EXC_ALE_IDX], ex.ale);
        chk("xf_rf", exe_rf_all, ex.rf);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] rkd, input logic rfm, input logic [7:0] mem,
                          input logic [5:0] rf);
    id_pc = pc; id_alu_op = OP_ADD; id_alu_src1 = s1; id_alu_src2 = s2;
    id_rkd_value = rkd; id_res_from_mem = rfm; id_mem_all = mem; id_rf_all = rf;
    id_exc_rf = '0; id_tlb_rf = '0; id_to_exe_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [31:0] rkd, input logic rfm, input logic [7:0] mem,
                      input logic [5:0] rf);
    int n = 0;
    logic acc;
    drive_id(pc, s1, s2, rkd, rfm, mem, rf);
    do begin
      @(negedge clk); acc = exe_allowin;
      cyc(); n++;
    end while (!acc && n < 50);
    if (!acc) begin n_chk++; n_err++; $display("FAIL accept_timeout: pc %0h not taken", pc); end
    id_to_exe_valid = 1'b0;
  endtask

  logic [31:0] st_a[4] = '{32'h1003, 32'h1002, 32'h1004, 32'h1000};
  logic [31:0] st_d[4] = '{32'h0000_00AB, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_1234};
  logic [7:0]  st_m[4] = '{M_STB, M_STH, M_STW, M_STH};
  logic [3:0]  st_s[4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0011};
  logic [31:0] st_w[4] = '{32'hABAB_ABAB, 32'h5678_5678, 32'hDEAD_BEEF, 32'h1234_1234};
  logic [1:0]  st_z[4] = '{SIZE_B, SIZE_H, SIZE_W, SIZE_H};

  logic [31:0] al_a[2] = '{32'h1001, 32'h1006};
  logic [7:0]  al_m[2] = '{M_LDH, M_STW};

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; id_to_exe_valid = 0; id_pc = 0; id_alu_op = 0; id_alu_src1 = 0;
    id_alu_src2 = 0; id_rkd_value = 0; id_res_from_mem = 0; id_mem_all = 0; id_rf_all = 0;
    id_exc_rf = 0; id_csr_rf = '0; id_tlb_rf = 0; mem_allowin = 1; mem_pipeline_block = 0;
    wb_pipeline_block = 0; cancel = 0; addr_ok = 0; data_ok = 0;
    repeat (3) cyc();
    resetn = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", exe_to_mem_valid, 0); chk("rst_req", req, 0);
    chk("rst_rf", exe_rf_all, 0); chk("rst_exc", exe_exc_rf, 0);
    chk("rst_tlb", exe_tlb_rf, 0); chk("rst_drop", exe_drop_data_ok, 0);
    chk("rst_allowin", exe_allowin, 1);
    cyc();

    // ld.w 0x1000 with addr_ok three cycles late
    hs_q.push_back('{32'h1000, 1'b0, SIZE_W, 4'h0, 32'h0});
    xf_q.push_back('{32'h100, 32'h1000, 1'b0, 6'h21});
    send(32'h100, 32'h0FF0, 32'h10, 32'h0, 1'b1, M_LDW, 6'h21);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_req", req, 1); chk("t1_addr", addr, 32'h1000);
      chk("t1_size", size, SIZE_W); chk("t1_rdygo_wait", exe_ready_go, 0);
      cyc();
    end
    addr_ok = 1; @(negedge clk); chk("t1_req_hs", req, 1); cyc(); addr_ok = 0;
    @(negedge clk); chk("t1_rdygo_done", exe_ready_go, 1); chk("t1_req_done", req, 0); cyc();
    data_ok = 1; @(negedge clk); chk("t1_nodrop", exe_drop_data_ok, 0); cyc(); data_ok = 0;

    // Stores: strobes, lane replication, size
    for (int i = 0; i < 4; i++) begin
      hs_q.push_back('{st_a[i], 1'b1, st_z[i], st_s[i], st_w[i]});
      xf_q.push_back('{32'h200 + i * 4, st_a[i], 1'b0, 6'h0});
      send(32'h200 + i * 4, st_a[i], 32'h0, st_d[i], 1'b0, st_m[i], 6'h0);
      addr_ok = 1;
      @(negedge clk);
      chk("st_wstrb", wstrb, st_s[i]); chk("st_wdata", wdata, st_w[i]);
      chk("st_size", size, st_z[i]); chk("st_rdygo", exe_ready_go, 1);
      cyc(); addr_ok = 0;
    end

    // Misaligned: no request, ready_go straight away, ALE flagged
    for (int i = 0; i < 2; i++) begin
      xf_q.push_back('{32'h300 + i * 4, al_a[i], 1'b1, 6'h22});
      send(32'h300 + i * 4, al_a[i], 32'h0, 32'h0, al_m[i] == M_LDH, al_m[i], 6'h22);
      @(negedge clk);
      chk("ale_req", req, 0); chk("ale_rdygo", exe_ready_go, 1);
      chk("ale_bit", exe_exc_rf[EXC_ALE_IDX], 1);
      cyc();
    end

    // Cancel while in REQ, handshake two cycles later -> one squashed request
    hs_q.push_back('{32'h2000, 1'b0, SIZE_W, 4'h0, 32'h0});
    send(32'h400, 32'h2000, 32'h0, 32'h0, 1'b1, M_LDW, 6'h23);
    @(negedge clk); chk("t4_req_idle", req, 1); cyc();
    cancel = 1; @(negedge clk); chk("t4_req_cancel", req, 1); cyc(); cancel = 0;
    @(negedge clk);
    chk("t4_req_zombie", req, 1); chk("t4_allowin_zombie", exe_allowin, 0);
    chk("t4_tomem_zombie", exe_to_mem_valid, 0); chk("t4_drop_pre", exe_drop_data_ok, 0);
    cyc();
    addr_ok = 1; @(negedge clk); chk("t4_req_hs", req, 1); cyc(); addr_ok = 0;
    @(negedge clk); chk("t4_drop_set", exe_drop_data_ok, 1); chk("t4_req_off", req, 0); cyc();
    @(negedge clk); chk("t4_drop_hold", exe_drop_data_ok, 1); cyc();
    data_ok = 1; @(negedge clk); chk("t4_drop_at_dok", exe_drop_data_ok, 1); cyc(); data_ok = 0;
    @(negedge clk); chk("t4_drop_clr", exe_drop_data_ok, 0); cyc();

    // Hazard blocks hold off the request
    hs_q.push_back('{32'h3000, 1'b1, SIZE_W, 4'hF, 32'h1122_3344});
    xf_q.push_back('{32'h500, 32'h3000, 1'b0, 6'h0});
    mem_pipeline_block = 1;
    send(32'h500, 32'h3000, 32'h0, 32'h1122_3344, 1'b0, M_STW, 6'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("t5_req_mblk", req, 0); chk("t5_rdygo_mblk", exe_ready_go, 0); cyc();
    end
    mem_pipeline_block = 0; wb_pipeline_block = 1;
    @(negedge clk); chk("t5_req_wblk", req, 0); cyc();
    wb_pipeline_block = 0;
    @(negedge clk); chk("t5_req_rise", req, 1); cyc();
    addr_ok = 1; @(negedge clk); cyc(); addr_ok = 0;
    @(negedge clk); cyc();

    // Back-to-back loads with MEM stalled while the first sits in DONE
    hs_q.push_back('{32'h4000, 1'b0, SIZE_W, 4'h0, 32'h0});
    hs_q.push_back('{32'h4004, 1'b0, SIZE_W, 4'h0, 32'h0});
    xf_q.push_back('{32'h600, 32'h4000, 1'b0, 6'h24});
    xf_q.push_back('{32'h604, 32'h4004, 1'b0, 6'h25});
    mem_allowin = 0;
    send(32'h600, 32'h4000, 32'h0, 32'h0, 1'b1, M_LDW, 6'h24);
    addr_ok = 1; @(negedge clk); cyc(); addr_ok = 0;
    drive_id(32'h604, 32'h4004, 32'h0, 32'h0, 1'b1, M_LDW, 6'h25);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_req_done", req, 0); chk("t6_allowin", exe_allowin, 0);
      chk("t6_tomem", exe_to_mem_valid, 1); chk("t6_pc", exe_pc, 32'h600);
      chk("t6_res", exe_result, 32'h4000);
      cyc();
    end
    mem_allowin = 1; @(negedge clk); cyc(); id_to_exe_valid = 0;
    addr_ok = 1; @(negedge clk); chk("t6_req2", req, 1); chk("t6_pc2", exe_pc, 32'h604);
    cyc(); addr_ok = 0;
    @(negedge clk); cyc();

    // Cancel and addr_ok together in REQ -> counted, back to IDLE
    hs_q.push_back('{32'h5000, 1'b0, SIZE_W, 4'h0, 32'h0});
    send(32'h700, 32'h5000, 32'h0, 32'h0, 1'b1, M_LDW, 6'h26);
    @(negedge clk); cyc();
    cancel = 1; addr_ok = 1; @(negedge clk); cyc(); cancel = 0; addr_ok = 0;
    @(negedge clk);
    chk("t7_drop", exe_drop_data_ok, 1); chk("t7_req", req, 0); chk("t7_allowin", exe_allowin, 1);
    cyc();

    // Reset in the middle of a request
    send(32'h800, 32'h5004, 32'h0, 32'h0, 1'b1, M_LDW, 6'h27);
    @(negedge clk); chk("t8_req_pre", req, 1); cyc();
    resetn = 0; cyc(); resetn = 1;
    @(negedge clk);
    chk("t8_req_rst", req, 0); chk("t8_drop_rst", exe_drop_data_ok, 0);
    chk("t8_tomem_rst", exe_to_mem_valid, 0); chk("t8_allowin_rst", exe_allowin, 1);
    cyc();

    repeat (3) cyc();
    chk("hs_q_empty", hs_q.size(), 0);
    chk("xf_q_empty", xf_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
